mem_port_arbiter: RTL

//  Shares one single-port unified memory between three requesters: SREC loader, fetch, mem stage (data).

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_arb_pick.sv | 38 +++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter: FSM states and one-hot owner ids.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_IDLE   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Owner ids are one-hot so a grant vector can be latched directly as the owner.
    localparam logic [2:0] OWN_LOAD  = 3'b001;
    localparam logic [2:0] OWN_FETCH = 3'b010;
    localparam logic [2:0] OWN_DATA  = 3'b100;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection for the memory port; produces a one-hot grant or zero.
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int CNT_W        = 3,
    parameter int STARVE_LIMIT = 4
) (
    input  logic [1:0]       state_i,
    input  logic             hold_i,
    input  logic             load_req_i,
    input  logic             load_done_i,
    input  logic             fetch_req_i,
    input  logic             data_req_i,
    input  logic [CNT_W-1:0] starve_cnt_i,
    output logic [2:0]       grant_o
);

    logic starved;
    assign starved = (starve_cnt_i == CNT_W'(STARVE_LIMIT));

    // hold_i covers the ack cycle, where the finished requester still shows req.
    always_comb begin
        grant_o = '0;
        if (!hold_i) begin
            case (state_i)
                ST_LOAD: begin
                    if (load_req_i && !load_done_i) grant_o = OWN_LOAD;
                end
                ST_IDLE: begin
                    if (fetch_req_i && (starved || !data_req_i)) grant_o = OWN_FETCH;
                    else if (data_req_i)                         grant_o = OWN_DATA;
                end
                default: grant_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: loader owns the port until load_done, then data/fetch share it.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_req,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_wdata,
    input  logic              load_done,
    output logic              load_ack,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [DATA_W-1:0] fetch_rdata,
    output logic              fetch_ack,
    output logic              fetch_stall,
    input  logic              data_req,
    input  logic              data_wren,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,
    output logic              data_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    logic [1:0]        state_q, state_d;
    logic [2:0]        owner_q, owner_d, grant;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              wren_q, wren_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [DATA_W-1:0] fetch_rdata_q, fetch_rdata_d, data_rdata_q, data_rdata_d;
    logic              load_ack_q, load_ack_d, fetch_ack_q, fetch_ack_d, data_ack_q, data_ack_d;
    logic              last;

    assign last = (state_q == ST_ACCESS) && (lat_q == LAT_W'(MEM_LATENCY - 1));

    mem_arb_pick #(
        .CNT_W        (CNT_W),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_pick (
        .state_i      (state_q),
        .hold_i       (load_ack_q | fetch_ack_q | data_ack_q),
        .load_req_i   (load_req),
        .load_done_i  (load_done),
        .fetch_req_i  (fetch_req),
        .data_req_i   (data_req),
        .starve_cnt_i (starve_q),
        .grant_o      (grant)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wren_d        = wren_q;
        lat_d         = lat_q;
        starve_d      = starve_q;
        fetch_rdata_d = fetch_rdata_q;
        data_rdata_d  = data_rdata_q;
        load_ack_d    = last && (owner_q == OWN_LOAD);
        fetch_ack_d   = last && (owner_q == OWN_FETCH);
        data_ack_d    = last && (owner_q == OWN_DATA);

        case (state_q)
            ST_LOAD: begin
                if (grant != '0)   state_d = ST_ACCESS;
                else if (load_done) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (grant != '0) state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (last) state_d = (owner_q == OWN_LOAD && !load_done) ? ST_LOAD : ST_IDLE;
                else      lat_d   = lat_q + 1'b1;
            end
            default: state_d = ST_LOAD;
        endcase

        if (grant != '0) begin
            owner_d = grant;
            lat_d   = '0;
            case (grant)
                OWN_LOAD: begin
                    addr_d  = load_addr;
                    wdata_d = load_wdata;
                    wren_d  = 1'b1;
                end
                OWN_FETCH: begin
                    addr_d  = fetch_addr;
                    wdata_d = '0;
                    wren_d  = 1'b0;
                end
                default: begin
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    wren_d  = data_wren;
                end
            endcase
        end

        // Write completions leave the read-data registers untouched.
        if (last && !wren_q) begin
            if (owner_q == OWN_FETCH) fetch_rdata_d = mem_rdata;
            if (owner_q == OWN_DATA)  data_rdata_d  = mem_rdata;
        end

        if (grant == OWN_FETCH)
            starve_d = '0;
        else if (grant == OWN_DATA && fetch_req && starve_q != CNT_W'(STARVE_LIMIT))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_LOAD;
            owner_q       <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wren_q        <= 1'b0;
            lat_q         <= '0;
            starve_q      <= '0;
            fetch_rdata_q <= '0;
            data_rdata_q  <= '0;
            load_ack_q    <= 1'b0;
            fetch_ack_q   <= 1'b0;
            data_ack_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wren_q        <= wren_d;
            lat_q         <= lat_d;
            starve_q      <= starve_d;
            fetch_rdata_q <= fetch_rdata_d;
            data_rdata_q  <= data_rdata_d;
            load_ack_q    <= load_ack_d;
            fetch_ack_q   <= fetch_ack_d;
            data_ack_q    <= data_ack_d;
        end
    end

    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign mem_wren    = (state_q == ST_ACCESS) && (lat_q == '0) && wren_q;
    assign load_ack    = load_ack_q;
    assign fetch_ack   = fetch_ack_q;
    assign data_ack    = data_ack_q;
    assign fetch_rdata = fetch_rdata_q;
    assign data_rdata  = data_rdata_q;
    assign fetch_stall = (state_q == ST_LOAD) || (fetch_req && !fetch_ack_q);
    assign busy        = (state_q != ST_IDLE);

endmodule
